// File: rtl/rot_quarter_scheduler_if.sv
// rtl/rot_quarter_scheduler_if.sv - channel, rotator and control signals of the quarter-turn scheduler
interface rot_quarter_scheduler_if #(
  parameter int G_DWIDTH = 24
);
  // control
  logic                enable;
  logic [1:0]          ch0_step;
  logic [1:0]          ch1_step;
  logic                phase_clear;
  // channel inputs
  logic [G_DWIDTH-1:0] ch0_din_re;
  logic [G_DWIDTH-1:0] ch0_din_im;
  logic                ch0_din_valid;
  logic                ch0_din_ready;
  logic [G_DWIDTH-1:0] ch1_din_re;
  logic [G_DWIDTH-1:0] ch1_din_im;
  logic                ch1_din_valid;
  logic                ch1_din_ready;
  // rotator request
  logic [G_DWIDTH-1:0] rot_re;
  logic [G_DWIDTH-1:0] rot_im;
  logic [1:0]          rot_index;
  logic                rot_valid;
  logic                rot_ready;
  // rotator result
  logic [G_DWIDTH-1:0] res_re;
  logic [G_DWIDTH-1:0] res_im;
  logic                res_valid;
  logic                res_ready;
  // channel outputs
  logic [G_DWIDTH-1:0] ch0_dout_re;
  logic [G_DWIDTH-1:0] ch0_dout_im;
  logic                ch0_dout_valid;
  logic                ch0_dout_ready;
  logic [G_DWIDTH-1:0] ch1_dout_re;
  logic [G_DWIDTH-1:0] ch1_dout_im;
  logic                ch1_dout_valid;
  logic                ch1_dout_ready;
  // status
  logic                busy;
  logic                grant;

  // scheduler side
  modport slave (
    input  enable, ch0_step, ch1_step, phase_clear,
    input  ch0_din_re, ch0_din_im, ch0_din_valid,
    output ch0_din_ready,
    input  ch1_din_re, ch1_din_im, ch1_din_valid,
    output ch1_din_ready,
    output rot_re, rot_im, rot_index, rot_valid,
    input  rot_ready,
    input  res_re, res_im, res_valid,
    output res_ready,
    output ch0_dout_re, ch0_dout_im, ch0_dout_valid,
    input  ch0_dout_ready,
    output ch1_dout_re, ch1_dout_im, ch1_dout_valid,
    input  ch1_dout_ready,
    output busy, grant
  );

  // environment side (channels, rotator, control)
  modport master (
    output enable, ch0_step, ch1_step, phase_clear,
    output ch0_din_re, ch0_din_im, ch0_din_valid,
    input  ch0_din_ready,
    output ch1_din_re, ch1_din_im, ch1_din_valid,
    input  ch1_din_ready,
    input  rot_re, rot_im, rot_index, rot_valid,
    output rot_ready,
    output res_re, res_im, res_valid,
    input  res_ready,
    input  ch0_dout_re, ch0_dout_im, ch0_dout_valid,
    output ch0_dout_ready,
    input  ch1_dout_re, ch1_dout_im, ch1_dout_valid,
    output ch1_dout_ready,
    input  busy, grant
  );
endinterface

// File: rtl/rot_quarter_scheduler.sv
// rtl/rot_quarter_scheduler.sv - round-robin sharing of one quarter-turn rotator between two channels
module rot_quarter_scheduler #(
  parameter int G_DWIDTH = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  rot_quarter_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    SM_INIT,
    SM_ARB,
    SM_ACCEPT,
    SM_ISSUE,
    SM_WAIT,
    SM_RETURN
  } state_t;

  state_t              state_q;
  logic                grant_q;
  logic                last_grant_q;
  logic [1:0]          phase0_q, phase0_d;
  logic [1:0]          phase1_q, phase1_d;
  logic                din_ready0_q, din_ready1_q;
  logic                rot_valid_q;
  logic [G_DWIDTH-1:0] rot_re_q, rot_im_q;
  logic [1:0]          rot_index_q;
  logic                res_ready_q;
  logic [G_DWIDTH-1:0] dout0_re_q, dout0_im_q, dout1_re_q, dout1_im_q;
  logic                dout_valid0_q, dout_valid1_q;
  logic                busy_q;

  logic                any_valid;
  logic                arb_g;
  logic                in_fire;
  logic                out_fire;

  // Arbitration: a lone requester wins; on contention the channel not served last wins.
  assign any_valid = bus.ch0_din_valid | bus.ch1_din_valid;
  assign arb_g     = (bus.ch0_din_valid & bus.ch1_din_valid) ? ~last_grant_q : bus.ch1_din_valid;
  assign in_fire   = grant_q ? (bus.ch1_din_valid & din_ready1_q) : (bus.ch0_din_valid & din_ready0_q);
  assign out_fire  = grant_q ? (dout_valid1_q & bus.ch1_dout_ready) : (dout_valid0_q & bus.ch0_dout_ready);

  // Phase accumulators: advance the granted channel on its accept, phase_clear overrides.
  always_comb begin
    phase0_d = phase0_q;
    phase1_d = phase1_q;
    if (state_q == SM_ACCEPT && in_fire) begin
      if (grant_q) phase1_d = phase1_q + bus.ch1_step;
      else         phase0_d = phase0_q + bus.ch0_step;
    end
    if (bus.phase_clear) begin
      phase0_d = 2'd0;
      phase1_d = 2'd0;
    end
  end

  // Transaction FSM; every handshake output is a register updated here.
  always_ff @(posedge clk) begin
    if (reset || !bus.enable) begin
      state_q       <= SM_INIT;
      grant_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      phase0_q      <= 2'd0;
      phase1_q      <= 2'd0;
      din_ready0_q  <= 1'b0;
      din_ready1_q  <= 1'b0;
      rot_valid_q   <= 1'b0;
      rot_index_q   <= 2'd0;
      res_ready_q   <= 1'b0;
      dout_valid0_q <= 1'b0;
      dout_valid1_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      phase0_q <= phase0_d;
      phase1_q <= phase1_d;
      case (state_q)
        SM_INIT: state_q <= SM_ARB;
        SM_ARB: begin
          if (any_valid) begin
            grant_q <= arb_g;
            if (arb_g) din_ready1_q <= 1'b1;
            else       din_ready0_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= SM_ACCEPT;
          end
        end
        SM_ACCEPT: begin
          if (in_fire) begin
            rot_re_q     <= grant_q ? bus.ch1_din_re : bus.ch0_din_re;
            rot_im_q     <= grant_q ? bus.ch1_din_im : bus.ch0_din_im;
            // the sample uses the pre-update phase, even when phase_clear hits this edge
            rot_index_q  <= grant_q ? phase1_q : phase0_q;
            din_ready0_q <= 1'b0;
            din_ready1_q <= 1'b0;
            rot_valid_q  <= 1'b1;
            state_q      <= SM_ISSUE;
          end
        end
        SM_ISSUE: begin
          if (bus.rot_ready) begin
            rot_valid_q <= 1'b0;
            res_ready_q <= 1'b1;
            state_q     <= SM_WAIT;
          end
        end
        SM_WAIT: begin
          if (bus.res_valid) begin
            if (grant_q) begin
              dout1_re_q    <= bus.res_re;
              dout1_im_q    <= bus.res_im;
              dout_valid1_q <= 1'b1;
            end else begin
              dout0_re_q    <= bus.res_re;
              dout0_im_q    <= bus.res_im;
              dout_valid0_q <= 1'b1;
            end
            res_ready_q <= 1'b0;
            state_q     <= SM_RETURN;
          end
        end
        SM_RETURN: begin
          if (out_fire) begin
            dout_valid0_q <= 1'b0;
            dout_valid1_q <= 1'b0;
            last_grant_q  <= grant_q;
            busy_q        <= 1'b0;
            state_q       <= SM_ARB;
          end
        end
        default: state_q <= SM_INIT;
      endcase
    end
  end

  assign bus.ch0_din_ready  = din_ready0_q;
  assign bus.ch1_din_ready  = din_ready1_q;
  assign bus.rot_re         = rot_re_q;
  assign bus.rot_im         = rot_im_q;
  assign bus.rot_index      = rot_index_q;
  assign bus.rot_valid      = rot_valid_q;
  assign bus.res_ready      = res_ready_q;
  assign bus.ch0_dout_re    = dout0_re_q;
  assign bus.ch0_dout_im    = dout0_im_q;
  assign bus.ch0_dout_valid = dout_valid0_q;
  assign bus.ch1_dout_re    = dout1_re_q;
  assign bus.ch1_dout_im    = dout1_im_q;
  assign bus.ch1_dout_valid = dout_valid1_q;
  assign bus.busy           = busy_q;
  assign bus.grant          = grant_q;

endmodule

// File: tb/tb_rot_quarter_scheduler.sv
// tb/tb_rot_quarter_scheduler.sv - directed self-checking bench for rot_quarter_scheduler
module tb_rot_quarter_scheduler;
  localparam int W = 24;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rot_quarter_scheduler_if #(.G_DWIDTH(W)) bus ();
  rot_quarter_scheduler #(.G_DWIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [47:0] q0[$], q1[$], rx0[$], rx1[$];
  logic [1:0]  log_idx[$];
  logic        log_g[$];
  int          log_cyc[$];

  logic        s0_fire = 0, s1_fire = 0, k0_fire = 0, k1_fire = 0, r_fire = 0, res_fire = 0;
  logic [47:0] k0_data, k1_data, rot_item;
  logic [1:0]  rot_item_idx;
  logic        rot_has = 0;
  int          rot_cnt = 0, rot_lat = 0;
  int          res_bad = 0, res_rdy_cyc = 0;
  logic        ch1_seen = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] pk(input int re, input int im);
    return {re[23:0], im[23:0]};
  endfunction

  // Reference quarter-turn rotator: (re + j*im) * j^k
  function automatic logic [47:0] rotq(input logic [47:0] s, input logic [1:0] k);
    logic [23:0] re, im, nre, nim;
    re = s[47:24]; im = s[23:0]; nre = -re; nim = -im;
    case (k)
      2'd0:    return s;
      2'd1:    return {nim, re};
      2'd2:    return {nre, nim};
      default: return {im, nre};
    endcase
  endfunction

  // channel sources: present queue head, pop after a transfer
  initial begin
    bus.ch0_din_valid = 0; bus.ch1_din_valid = 0;
    bus.ch0_din_re = 0; bus.ch0_din_im = 0; bus.ch1_din_re = 0; bus.ch1_din_im = 0;
    forever begin
      @(negedge clk);
      if (s0_fire && q0.size() > 0) q0.delete(0);
      if (s1_fire && q1.size() > 0) q1.delete(0);
      bus.ch0_din_valid = (q0.size() > 0);
      bus.ch1_din_valid = (q1.size() > 0);
      if (q0.size() > 0) {bus.ch0_din_re, bus.ch0_din_im} = q0[0];
      if (q1.size() > 0) {bus.ch1_din_re, bus.ch1_din_im} = q1[0];
      #4;
      s0_fire = bus.ch0_din_valid && bus.ch0_din_ready;
      s1_fire = bus.ch1_din_valid && bus.ch1_din_ready;
    end
  end

  // channel sinks: collect results on transfer
  initial begin
    forever begin
      @(negedge clk);
      if (k0_fire) rx0.push_back(k0_data);
      if (k1_fire) rx1.push_back(k1_data);
      #4;
      k0_fire = bus.ch0_dout_valid && bus.ch0_dout_ready;
      k1_fire = bus.ch1_dout_valid && bus.ch1_dout_ready;
      if (k0_fire) k0_data = {bus.ch0_dout_re, bus.ch0_dout_im};
      if (k1_fire) k1_data = {bus.ch1_dout_re, bus.ch1_dout_im};
    end
  end

  // rotator with configurable latency; logs every issued request
  initial begin
    bus.res_valid = 0; bus.res_re = 0; bus.res_im = 0;
    rot_item = 0; rot_item_idx = 0;
    forever begin
      @(negedge clk);
      if (res_fire) rot_has = 0;
      if (r_fire) begin rot_has = 1; rot_cnt = rot_lat; end
      else if (rot_has && rot_cnt > 0) rot_cnt--;
      bus.res_valid = rot_has && (rot_cnt == 0);
      {bus.res_re, bus.res_im} = rotq(rot_item, rot_item_idx);
      #4;
      r_fire   = bus.rot_valid && bus.rot_ready;
      res_fire = bus.res_valid && bus.res_ready;
      if (r_fire) begin
        rot_item     = {bus.rot_re, bus.rot_im};
        rot_item_idx = bus.rot_index;
        log_idx.push_back(bus.rot_index);
        log_g.push_back(bus.grant);
        log_cyc.push_back(cyc);
      end
    end
  end

  // cycle counter and passive observers
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      #2;
      if (bus.ch1_dout_valid) ch1_seen = 1;
      if (bus.res_ready) res_rdy_cyc++;
      if (bus.res_ready && (bus.rot_valid || bus.ch0_din_ready || bus.ch1_din_ready ||
                            bus.ch0_dout_valid || bus.ch1_dout_valid || !bus.busy)) res_bad++;
    end
  end

  task automatic check_idle(input string tag);
    check({tag, "_hs"}, {bus.ch0_din_ready, bus.ch1_din_ready, bus.rot_valid, bus.res_ready,
                         bus.ch0_dout_valid, bus.ch1_dout_valid, bus.busy, bus.grant}, 0);
    check({tag, "_idx"}, bus.rot_index, 0);
  endtask

  task automatic apply_reset();
    reset = 1;
    @(negedge clk); #3;
    q0.delete(); q1.delete(); rx0.delete(); rx1.delete();
    log_idx.delete(); log_g.delete(); log_cyc.delete();
    rot_has = 0;
    @(negedge clk); #3;
    check_idle("rst");
    reset = 0;
  endtask

  task automatic wait_rx(input int n0, input int n1, input string tag);
    for (int i = 0; i < 2000; i++) begin
      if (rx0.size() >= n0 && rx1.size() >= n1) break;
      @(negedge clk); #3;
    end
    check(tag, rx0.size() + rx1.size(), n0 + n1);
  endtask

  int          e1_idx[5] = '{0, 1, 2, 3, 0};
  int          e2_idx[8] = '{0, 0, 1, 3, 2, 2, 3, 1};
  int          e2_g[8]   = '{0, 1, 0, 1, 0, 1, 0, 1};
  int          e5_idx[4] = '{0, 1, 2, 0};
  logic [47:0] e1_out[5], c0_in[4], c1_in[4], e0_out[4], e1c_out[4];
  logic [63:0] snap;
  int          unstable, rdy_bad;

  initial begin
    reset = 1;
    bus.enable = 1; bus.ch0_step = 0; bus.ch1_step = 0; bus.phase_clear = 0;
    bus.rot_ready = 1; bus.ch0_dout_ready = 1; bus.ch1_dout_ready = 1;
    e1_out  = '{pk(100, 0), pk(0, 100), pk(-100, 0), pk(0, -100), pk(100, 0)};
    c0_in   = '{pk(10, 20), pk(30, 40), pk(50, 60), pk(70, 80)};
    c1_in   = '{pk(-5, 7), pk(9, -11), pk(13, 15), pk(-17, -19)};
    e0_out  = '{pk(10, 20), pk(-40, 30), pk(-50, -60), pk(80, -70)};
    e1c_out = '{pk(-5, 7), pk(-11, -9), pk(-13, -15), pk(19, -17)};
    repeat (2) @(negedge clk);
    #3;

    // ch0 alone, step +1
    bus.ch0_step = 1; rot_lat = 0;
    apply_reset();
    ch1_seen = 0;
    for (int i = 0; i < 5; i++) q0.push_back(pk(100, 0));
    wait_rx(5, 0, "t1_count");
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t1_idx%0d", i), log_idx[i], e1_idx[i]);
      check($sformatf("t1_out%0d", i), rx0[i], e1_out[i]);
    end
    check("t1_rate", log_cyc[1] - log_cyc[0], 5);
    check("t1_ch1_quiet", ch1_seen, 0);

    // both channels contending, ch0 +1, ch1 -1
    bus.ch0_step = 1; bus.ch1_step = 3;
    apply_reset();
    for (int i = 0; i < 4; i++) begin q0.push_back(c0_in[i]); q1.push_back(c1_in[i]); end
    wait_rx(4, 4, "t2_count");
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t2_g%0d", i), log_g[i], e2_g[i]);
      check($sformatf("t2_idx%0d", i), log_idx[i], e2_idx[i]);
    end
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_ch0_%0d", i), rx0[i], e0_out[i]);
      check($sformatf("t2_ch1_%0d", i), rx1[i], e1c_out[i]);
    end

    // backpressure on rotator then on ch0 output
    bus.ch0_step = 1; bus.ch1_step = 1;
    apply_reset();
    bus.rot_ready = 0;
    q0.push_back(pk('h123, 'h456)); q1.push_back(pk('h777, 'h888));
    for (int i = 0; i < 40; i++) begin @(negedge clk); #3; if (bus.rot_valid) break; end
    check("t3_rot_valid", bus.rot_valid, 1);
    snap = {bus.rot_re, bus.rot_im, bus.rot_index};
    unstable = 0; rdy_bad = 0;
    repeat (10) begin
      @(negedge clk); #3;
      if ({bus.rot_re, bus.rot_im, bus.rot_index} !== snap[49:0] || !bus.rot_valid) unstable++;
      if (bus.ch0_din_ready || bus.ch1_din_ready) rdy_bad++;
    end
    check("t3_rot_hold", unstable, 0);
    check("t3_rot_data", snap, {14'd0, 24'h123, 24'h456, 2'd0});
    bus.ch0_dout_ready = 0; bus.rot_ready = 1;
    for (int i = 0; i < 40; i++) begin @(negedge clk); #3; if (bus.ch0_dout_valid) break; end
    check("t3_dout_valid", bus.ch0_dout_valid, 1);
    snap = {16'd0, bus.ch0_dout_re, bus.ch0_dout_im};
    unstable = 0;
    repeat (7) begin
      @(negedge clk); #3;
      if ({bus.ch0_dout_re, bus.ch0_dout_im} !== snap[47:0] || !bus.ch0_dout_valid) unstable++;
      if (bus.ch0_din_ready || bus.ch1_din_ready) rdy_bad++;
    end
    check("t3_dout_hold", unstable, 0);
    check("t3_no_ready", rdy_bad, 0);
    bus.ch0_dout_ready = 1;
    wait_rx(1, 1, "t3_count");
    check("t3_ch0", rx0[0], pk('h123, 'h456));
    check("t3_ch1", rx1[0], pk('h777, 'h888));
    check("t3_g1", log_g[1], 1);

    // long rotator latency keeps ordering; res_ready only while waiting
    bus.ch0_step = 1; bus.ch1_step = 3; rot_lat = 20;
    apply_reset();
    res_bad = 0; res_rdy_cyc = 0;
    for (int i = 0; i < 2; i++) begin q0.push_back(c0_in[i]); q1.push_back(c1_in[i]); end
    wait_rx(2, 2, "t4_count");
    for (int i = 0; i < 2; i++) begin
      check($sformatf("t4_ch0_%0d", i), rx0[i], e0_out[i]);
      check($sformatf("t4_ch1_%0d", i), rx1[i], e1c_out[i]);
    end
    check("t4_order", {log_g[0], log_g[1], log_g[2], log_g[3]}, 4'b0101);
    check("t4_res_ready_excl", res_bad, 0);
    check("t4_res_ready_cyc", res_rdy_cyc, 84);

    // phase_clear on the accept edge of ch0's third sample
    bus.ch0_step = 1; bus.ch1_step = 0; rot_lat = 0;
    apply_reset();
    q0.push_back(pk(1, 2)); q0.push_back(pk(3, 4));
    wait_rx(2, 0, "t5_pre");
    q0.push_back(pk(5, 6)); q0.push_back(pk(7, 8));
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #3;
      if (bus.ch0_din_ready && bus.ch0_din_valid) break;
    end
    check("t5_accept_seen", bus.ch0_din_ready, 1);
    bus.phase_clear = 1;
    @(negedge clk); #3;
    bus.phase_clear = 0;
    wait_rx(4, 0, "t5_count");
    for (int i = 0; i < 4; i++) check($sformatf("t5_idx%0d", i), log_idx[i], e5_idx[i]);

    // enable dropped during SM_WAIT
    bus.ch0_step = 1; bus.ch1_step = 1; rot_lat = 20;
    apply_reset();
    q0.push_back(pk(5, 6));
    for (int i = 0; i < 40; i++) begin @(negedge clk); #3; if (bus.res_ready) break; end
    check("t6_in_wait", bus.res_ready, 1);
    bus.enable = 0;
    @(negedge clk); #3;
    check_idle("t6_drop");
    bus.enable = 1;
    rot_has = 0; rot_lat = 0;
    log_idx.delete(); log_g.delete(); log_cyc.delete();
    q0.push_back(pk(7, 8)); q1.push_back(pk(9, 10));
    wait_rx(1, 1, "t6_count");
    check("t6_rx0_n", rx0.size(), 1);
    check("t6_g0", log_g[0], 0);
    check("t6_idx0", log_idx[0], 0);
    check("t6_idx1", log_idx[1], 0);
    check("t6_ch0", rx0[0], pk(7, 8));
    check("t6_ch1", rx1[0], pk(9, 10));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
